// File: rtl/ula_acumulador_pkg.sv
// Shared definitions for the accumulator/sequencer: command-kind codes,
// FSM state encodings and the ALU function-select codes, so the ALU,
// this block and any upstream command source agree on the encodings.
package ula_acumulador_pkg;

  // Default datapath and repeat-field widths (WIDTH must match the ALU)
  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 4;

  // Command kinds carried on cmd_kind
  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_EXEC  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_kind_e;

  // Sequencer states; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // ALU function selects. This block passes sel through untouched; the
  // codes live here only so the ALU and command sources share them.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/ula_acumulador_if.sv
// Command channel into the accumulator: valid/ready handshake plus the
// command payload. The command source is the master; the accumulator is
// the slave and only returns cmd_ready.
interface ula_acumulador_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_kind;
  logic [1:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_operand;
  logic [REP_W-1:0] cmd_rep;

  modport master (
    output cmd_valid,
    output cmd_kind,
    output cmd_sel,
    output cmd_operand,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_kind,
    input  cmd_sel,
    input  cmd_operand,
    input  cmd_rep,
    output cmd_ready
  );

endinterface

// File: rtl/ula_acumulador.sv
// Accumulator and sequencer around an external combinational ALU.
// Commands arrive on a valid/ready channel. LOAD/CLEAR/NOP complete in
// one cycle; EXEC drives the ALU with (acc, operand, sel) and captures its
// result back into acc for cmd_rep+1 consecutive cycles, so repeated
// operations (e.g. multiply-by-repeated-add) need a single command.
// The ALU sits beside this block in the enclosing level; alu_a always
// mirrors acc, giving a one-cycle acc -> ALU -> acc loop.
module ula_acumulador
  import ula_acumulador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  ula_acumulador_if.slave  cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             done
);

  state_e           state;
  logic [WIDTH-1:0] opnd_r;
  logic [1:0]       sel_r;
  logic [REP_W-1:0] cnt;
  logic             ready_r;
  logic             accept;
  cmd_kind_e        kind;

  // ready_r is a registered copy of (state == ST_IDLE), so accept needs
  // no decode of the state vector on the handshake path.
  assign accept        = cmd.cmd_valid && ready_r;
  assign kind          = cmd_kind_e'(cmd.cmd_kind);
  assign cmd.cmd_ready = ready_r;

  // ALU operands come straight from registers; no logic in this path
  assign alu_a   = acc;
  assign alu_b   = opnd_r;
  assign alu_sel = sel_r;

  // Sequencer FSM with accumulator, flags, repeat counter and the
  // registered handshake/done outputs, all updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b1;
      opnd_r  <= '0;
      sel_r   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_r <= 1'b0;
            case (kind)
              CMD_LOAD: begin
                acc    <= cmd.cmd_operand;
                flag_c <= 1'b0;
                flag_z <= (cmd.cmd_operand == '0);
                done   <= 1'b1;
                state  <= ST_DONE;
              end
              CMD_CLEAR: begin
                acc    <= '0;
                flag_c <= 1'b0;
                flag_z <= 1'b1;
                done   <= 1'b1;
                state  <= ST_DONE;
              end
              CMD_EXEC: begin
                // acc and flags stay put until the first ALU capture
                opnd_r <= cmd.cmd_operand;
                sel_r  <= cmd.cmd_sel;
                cnt    <= cmd.cmd_rep;
                state  <= ST_RUN;
              end
              default: begin
                // NOP: only walks through DONE to produce the pulse
                done  <= 1'b1;
                state <= ST_DONE;
              end
            endcase
          end
        end

        ST_RUN: begin
          // Capture the ALU every cycle; flags reflect the latest result
          acc    <= alu_f;
          flag_c <= alu_cout;
          flag_z <= (alu_f == '0);
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - REP_W'(1);
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          ready_r <= 1'b1;
          state   <= ST_IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to an idle, ready state
          done    <= 1'b0;
          ready_r <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_acumulador.sv
// Bench for ula_acumulador with a combinational 4-bit ALU stub
// (00 add, 01 and, 10 or, 11 xor, carry-in 0). A scoreboard entry with
// the expected acc/flags and the expected done cycle is pushed on every
// accepted command and checked against each done pulse.
module tb_ula_acumulador;
  import ula_acumulador_pkg::*;

  localparam int WIDTH = 4;
  localparam int REP_W = 4;

  typedef struct {
    logic [3:0] acc;
    logic       c;
    logic       z;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_f, acc;
  logic [1:0] alu_sel;
  logic       alu_cout, flag_c, flag_z, done;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   accept_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t e;
  logic [3:0] m_acc = 4'h0;
  logic       m_c = 1'b0;
  logic       m_z = 1'b1;

  always #5 clk = ~clk;

  ula_acumulador_if #(.WIDTH(WIDTH), .REP_W(REP_W)) cmd_bus ();

  ula_acumulador #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_f    (alu_f),
    .alu_cout (alu_cout),
    .acc      (acc),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .done     (done)
  );

  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] sel);
    case (sel)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_AND: return {1'b0, a & b};
      ALU_OR:  return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // ALU stub standing in for the real bit-slice ALU
  assign {alu_cout, alu_f} = alu_ref(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: completion checks, reset flush, and model update on accept
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("done  cyc=%0d acc=%h c=%b z=%b (exp acc=%h c=%b z=%b cyc=%0d)",
                 cyc, acc, flag_c, flag_z, e.acc, e.c, e.z, e.done_cyc);
        check("done_cycle", cyc, e.done_cyc);
        check("acc", acc, e.acc);
        check("flag_c", flag_c, e.c);
        check("flag_z", flag_z, e.z);
      end
    end
    if (rst) begin
      accept_cnt -= sb.size();
      sb.delete();
      m_acc = 4'h0;
      m_c   = 1'b0;
      m_z   = 1'b1;
    end else if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
      accept_cnt++;
      e.done_cyc = cyc + 1;
      case (cmd_bus.cmd_kind)
        2'b00: begin
          m_acc = cmd_bus.cmd_operand;
          m_c   = 1'b0;
          m_z   = (cmd_bus.cmd_operand == 4'h0);
        end
        2'b10: begin
          m_acc = 4'h0;
          m_c   = 1'b0;
          m_z   = 1'b1;
        end
        2'b01: begin
          for (int i = 0; i <= int'(cmd_bus.cmd_rep); i++) begin
            logic [4:0] r;
            r = alu_ref(m_acc, cmd_bus.cmd_operand, cmd_bus.cmd_sel);
            m_acc = r[3:0];
            m_c   = r[4];
            m_z   = (r[3:0] == 4'h0);
          end
          e.done_cyc = cyc + 2 + int'(cmd_bus.cmd_rep);
        end
        default: ;
      endcase
      e.acc = m_acc;
      e.c   = m_c;
      e.z   = m_z;
      sb.push_back(e);
      $display("acc'd cyc=%0d kind=%b sel=%b op=%h rep=%0d", cyc + 1, cmd_bus.cmd_kind,
               cmd_bus.cmd_sel, cmd_bus.cmd_operand, cmd_bus.cmd_rep);
    end
  end

  // All driving happens just after a rising edge; valid stays high after
  // accept unless the caller drops it.
  task automatic send(input logic [1:0] kind, input logic [1:0] sel,
                      input logic [3:0] op, input logic [3:0] rep);
    bit ok;
    ok = 1'b0;
    cmd_bus.cmd_valid   = 1'b1;
    cmd_bus.cmd_kind    = kind;
    cmd_bus.cmd_sel     = sel;
    cmd_bus.cmd_operand = op;
    cmd_bus.cmd_rep     = rep;
    for (int i = 0; i < 100; i++) begin
      if (cmd_bus.cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && cmd_bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input logic [1:0] kind, input logic [1:0] sel,
                      input logic [3:0] op, input logic [3:0] rep);
    send(kind, sel, op, rep);
    idle();
    wait_idle();
  endtask

  initial begin
    int d0;
    cmd_bus.cmd_valid   = 1'b0;
    cmd_bus.cmd_kind    = 2'b11;
    cmd_bus.cmd_sel     = 2'b00;
    cmd_bus.cmd_operand = 4'h0;
    cmd_bus.cmd_rep     = 4'h0;

    // Reset held for two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc, 4'h0);
    check("rst_flag_z", flag_z, 1'b1);
    check("rst_flag_c", flag_c, 1'b0);
    check("rst_ready", cmd_bus.cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LOAD 5, add 3 once -> 8
    run1(2'b00, ALU_ADD, 4'h5, 4'h0);
    run1(2'b01, ALU_ADD, 4'h3, 4'h0);
    check("add_once_acc", acc, 4'h8);
    check("add_once_c", flag_c, 1'b0);
    check("add_once_z", flag_z, 1'b0);

    // LOAD 0, five adds of 3 -> F; then +1 wraps to 0 with carry
    run1(2'b00, ALU_ADD, 4'h0, 4'h0);
    run1(2'b01, ALU_ADD, 4'h3, 4'h4);
    check("rep_add_acc", acc, 4'hF);
    check("rep_add_c", flag_c, 1'b0);
    run1(2'b01, ALU_ADD, 4'h1, 4'h0);
    check("wrap_acc", acc, 4'h0);
    check("wrap_c", flag_c, 1'b1);
    check("wrap_z", flag_z, 1'b1);

    // Max repeat: 16 adds of 1 from 0 -> 0 with carry from the last add
    run1(2'b00, ALU_ADD, 4'h0, 4'h0);
    run1(2'b01, ALU_ADD, 4'h1, 4'hF);
    check("maxrep_acc", acc, 4'h0);
    check("maxrep_c", flag_c, 1'b1);

    // Valid held high across alternating commands, including logic ops
    d0 = done_cnt;
    send(2'b00, ALU_ADD, 4'h3, 4'h0);
    send(2'b01, ALU_ADD, 4'h2, 4'h1);
    check("busy_ready_low", cmd_bus.cmd_ready, 1'b0);
    send(2'b11, ALU_ADD, 4'h0, 4'h0);
    send(2'b01, ALU_XOR, 4'h6, 4'h0);
    send(2'b10, ALU_ADD, 4'h0, 4'h0);
    send(2'b00, ALU_ADD, 4'hC, 4'h0);
    send(2'b01, ALU_AND, 4'hA, 4'h2);
    send(2'b01, ALU_OR, 4'h3, 4'h0);
    idle();
    wait_idle();
    check("held_done_count", done_cnt - d0, 32'd8);
    check("held_result", acc, 4'hB);

    // Reset in the middle of a long EXEC aborts it without a done pulse
    run1(2'b00, ALU_ADD, 4'h2, 4'h0);
    d0 = done_cnt;
    send(2'b01, ALU_ADD, 4'h1, 4'h7);
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_acc", acc, 4'h0);
    check("midrst_z", flag_z, 1'b1);
    check("midrst_c", flag_c, 1'b0);
    check("midrst_ready", cmd_bus.cmd_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 32'd0);
    run1(2'b00, ALU_ADD, 4'hA, 4'h0);
    check("post_rst_load", acc, 4'hA);

    // CLEAR after nonzero, then NOP leaves everything but still pulses done
    run1(2'b01, ALU_ADD, 4'h7, 4'h0);
    run1(2'b10, ALU_ADD, 4'h0, 4'h0);
    check("clear_acc", acc, 4'h0);
    check("clear_z", flag_z, 1'b1);
    check("clear_c", flag_c, 1'b0);
    run1(2'b00, ALU_ADD, 4'h9, 4'h0);
    d0 = done_cnt;
    run1(2'b11, ALU_ADD, 4'h4, 4'h0);
    check("nop_acc", acc, 4'h9);
    check("nop_z", flag_z, 1'b0);
    check("nop_done", done_cnt - d0, 32'd1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    check("accept_vs_done", accept_cnt, done_cnt);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
